// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 8;

    // Bits needed to count 0..w inclusive.
    function automatic int mult_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier, bit counter.
module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_nxt_o,
    output logic               last_o
);

    localparam int CW = mult_cnt_w(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Partial sum for this step; also the final product on the last step.
    assign acc_nxt_o = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o    = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
        end else if (step_i) begin
            acc_d    = acc_nxt_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per clock,
// valid/ready on both sides with synchronous abort.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    mult_state_t        state_q, state_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               last;
    logic               load, step, fin;

    mult_shift_add_dp #(
        .WIDTH     (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .step_i    (step),
        .a_i       (a),
        .b_i       (b),
        .acc_nxt_o (acc_nxt),
        .last_o    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
        end
    end

    // Abort wins over accept, step completion and out_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!abort && in_valid) state_d = RUN;
            RUN: begin
                if (abort)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: if (abort || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load   = (state_q == IDLE) && in_valid && !abort;
        step   = (state_q == RUN) && !abort;
        fin    = step && last;
        prod_d = fin ? acc_nxt : prod_q;
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = prod_q;

endmodule
